pulse_gen_arbiter: RTL

//  Round-robin scheduler that shares one single-shot pulse generator among N_REQ requesters.

---
 rtl/pulse_gen_arbiter_if.sv | 49 ++++
 rtl/pulse_gen_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pulse_gen_arbiter_if.sv
// Bundle between requesters, the shared pulse generator and the round-robin arbiter.
// Latency: none, wires only.
// Backpressure: none; req is a level held by each requester until its done strobe.
// Ports (signals):
//   req     : level request per requester        (requester -> arbiter)
//   pg_y    : pulse generator output             (generator -> arbiter)
//   pg_trig : 1-cycle trigger to the generator   (arbiter -> generator)
//   grant   : one-hot current owner, 0 when idle (arbiter -> requesters)
//   owner   : index of current or last owner
//   done    : 1-cycle one-hot completion strobe
//   y_route : pg_y steered to the owner's bit
//   err     : sticky generator timing mismatch flag
interface pulse_gen_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req;
  logic             pg_y;
  logic             pg_trig;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  owner;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] y_route;
  logic             err;

  // master: requesters plus generator side (drives req and pg_y)
  modport master (
    output req,
    output pg_y,
    input  pg_trig,
    input  grant,
    input  owner,
    input  done,
    input  y_route,
    input  err
  );

  // slave: the arbiter itself
  modport slave (
    input  req,
    input  pg_y,
    output pg_trig,
    output grant,
    output owner,
    output done,
    output y_route,
    output err
  );
endinterface

// File: rtl/pulse_gen_arbiter.sv
// Round-robin scheduler sharing one single-shot pulse generator among N_REQ requesters.
// Latency: req seen in IDLE at c -> pg_trig at c+1, done at c+2+HIGH_CYC+GAP_CYC.
// Backpressure: none; requests wait (level held) until IDLE, non-owners ignored meanwhile.
// Ports:
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset (shared with the generator)
//   bus  : pulse_gen_arbiter_if.slave (req/pg_y in; pg_trig/grant/owner/done/y_route/err out)
module pulse_gen_arbiter #(
  parameter int N_REQ    = 4,
  parameter int HIGH_CYC = 3,
  parameter int GAP_CYC  = 2,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rstn,
  pulse_gen_arbiter_if.slave bus
);

  localparam int MAX_CYC = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [ID_W-1:0]  LAST_IDX  = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRIG,
    S_HIGH,
    S_GAP
  } state_e;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [ID_W-1:0]  rr_ptr_q,  rr_ptr_d;
  logic [ID_W-1:0]  owner_q,   owner_d;
  logic [N_REQ-1:0] grant_q,   grant_d;
  logic [N_REQ-1:0] done_q,    done_d;
  logic             pg_trig_q, pg_trig_d;
  logic             err_q,     err_d;

  logic             win_vld;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W-1:0]  cand_idx;
  int               cand;
  logic [N_REQ-1:0] owner_oh;
  logic             y_mismatch;

  assign owner_oh = N_REQ'(1) << owner_q;

  // Round-robin pick: first asserted req at or above rr_ptr, wrapping past N_REQ-1.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = ID_W'(cand);
      if (!win_vld && bus.req[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  // Generator has no busy output, so the FSM mirrors its HIGH/GAP timing; TRIG is only
  // reachable from IDLE, i.e. after a complete HIGH+GAP window, so triggers never overlap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    done_d    = '0;
    pg_trig_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d   = N_REQ'(1) << win_idx;
          owner_d   = win_idx;
          pg_trig_d = 1'b1;
          state_d   = S_TRIG;
        end
      end
      S_TRIG: begin
        cnt_d   = '0;
        state_d = S_HIGH;
      end
      S_HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d    = '0;
          grant_d  = '0;
          done_d   = owner_oh;
          rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // pg_y must be high exactly while HIGH, low everywhere else.
  assign y_mismatch = (state_q == S_HIGH) ? !bus.pg_y : bus.pg_y;
  assign err_d      = err_q | y_mismatch;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      pg_trig_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      pg_trig_q <= pg_trig_d;
      err_q     <= err_d;
    end
  end

  assign bus.pg_trig = pg_trig_q;
  assign bus.grant   = grant_q;
  assign bus.owner   = owner_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.y_route = grant_q & {N_REQ{bus.pg_y}};

endmodule
